// File: rtl/clk_ctrl_pkg.sv
// Shared types and helpers for the CPU clock-enable controller.
// Holds the state encoding, rate-select codes and tick period lookup.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] RATE_1HZ   = 2'b00;
    localparam logic [1:0] RATE_100HZ = 2'b01;
    localparam logic [1:0] RATE_10KHZ = 2'b10;
    localparam logic [1:0] RATE_FULL  = 2'b11;

    localparam int unsigned DIV_100HZ = 100;
    localparam int unsigned DIV_10KHZ = 10_000;

    // Cycles between enables for a rate code; never below one cycle.
    function automatic logic [31:0] tick_period(
        input logic [1:0]  sel,
        input int unsigned clk_hz
    );
        int unsigned p;
        case (sel)
            RATE_1HZ:   p = clk_hz;
            RATE_100HZ: p = clk_hz / DIV_100HZ;
            RATE_10KHZ: p = clk_hz / DIV_10KHZ;
            default:    p = 1;
        endcase
        if (p == 0) begin
            p = 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a stability filter.
// Emits the filtered level and a one-cycle pulse on each filtered rise.
module input_debounce
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic rise_out
);

    localparam int unsigned CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronized input disagrees with the
    // accepted level; accept it once it has held for the full window.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer, filter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out = level_q;
    assign rise_out  = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller producing a single-cycle core clock enable.
// Also counts issued enables for the instruction display.
module cpu_clk_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [1:0]  rate_sel,
    input  logic        halt_req,
    input  logic        cnt_clr,
    output logic        cpu_ce,
    output logic [1:0]  state_o,
    output logic        halted,
    output logic [31:0] cycle_count
);

    logic        run_lvl;
    logic        run_rise_unused;
    logic        step_lvl_unused;
    logic        step_rise;

    ctrl_state_t state_q, state_d;
    logic [31:0] tick_q, tick_d;
    logic [1:0]  rate_q, rate_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        halted_q, halted_d;
    logic [31:0] period;
    logic        tick_last;

    input_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (run_sw),
        .level_out (run_lvl),
        .rise_out  (run_rise_unused)
    );

    input_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (step_btn),
        .level_out (step_lvl_unused),
        .rise_out  (step_rise)
    );

    // Enable comes from registered state only; a dropped run level
    // suppresses the pending tick in RUN.
    always_comb begin
        period    = tick_period(rate_q, CLK_HZ);
        tick_last = (tick_q == period - 32'd1);
        cpu_ce    = (state_q == STEP) ||
                    ((state_q == RUN) && run_lvl && tick_last);
    end

    // Next-state selection, priorities in order of the branches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALT: begin
                if (run_lvl) begin
                    state_d = RUN;
                end else if (step_rise) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (halt_req && cpu_ce) begin
                    state_d = BREAK;
                end else if (!run_lvl) begin
                    state_d = HALT;
                end
            end
            STEP: begin
                state_d = halt_req ? BREAK : HALT;
            end
            BREAK: begin
                if (step_rise) begin
                    state_d = STEP;
                end else if (!run_lvl) begin
                    state_d = HALT;
                end
            end
        endcase
    end

    // Tick counter runs only while staying in RUN at an unchanged rate.
    always_comb begin
        rate_d = rate_sel;
        tick_d = '0;
        if ((state_q == RUN) && (state_d == RUN)) begin
            if (rate_sel != rate_q) begin
                tick_d = '0;
            end else if (tick_last) begin
                tick_d = '0;
            end else begin
                tick_d = tick_q + 32'd1;
            end
        end
    end

    // Enable counter with clear taking precedence over increment.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (cnt_clr) begin
            cycle_count_d = '0;
        end else if (cpu_ce) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        halted_d = (state_d == HALT) || (state_d == BREAK);
    end

    // Controller state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HALT;
            tick_q        <= '0;
            rate_q        <= '0;
            cycle_count_q <= '0;
            halted_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            rate_q        <= rate_d;
            cycle_count_q <= cycle_count_d;
            halted_q      <= halted_d;
        end
    end

    assign state_o     = state_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for the clock-enable controller.
// Small timing config: CLK_HZ=10_000, DEBOUNCE_CYCLES=4.
module tb_cpu_clk_ctrl;
    import clk_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_sw;
    logic        step_btn;
    logic [1:0]  rate_sel;
    logic        halt_req;
    logic        cnt_clr;
    logic        cpu_ce;
    logic [1:0]  state_o;
    logic        halted;
    logic [31:0] cycle_count;

    int          checks = 0;
    int          errors = 0;
    int          ce_total = 0;
    logic [31:0] model_cnt = '0;
    logic        preload = 1'b0;

    cpu_clk_ctrl #(
        .CLK_HZ          (10_000),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run_sw      (run_sw),
        .step_btn    (step_btn),
        .rate_sel    (rate_sel),
        .halt_req    (halt_req),
        .cnt_clr     (cnt_clr),
        .cpu_ce      (cpu_ce),
        .state_o     (state_o),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Reference enable counter, updated mid-cycle ahead of the DUT edge.
    always @(negedge clk) begin
        if (cpu_ce && !rst) ce_total = ce_total + 1;
        if (rst || cnt_clr) model_cnt = '0;
        else if (preload) model_cnt = 32'hFFFF_FFFF + {31'b0, cpu_ce};
        else if (cpu_ce) model_cnt = model_cnt + 32'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input ctrl_state_t s, input int max,
                              input string tag);
        int n = 0;
        while (state_o !== 2'(s) && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(state_o), 32'(s));
    endtask

    initial begin
        int n;
        int last;
        int start;
        int rise_i;
        int ce_i;
        int bad;
        logic [1:0] st [0:29];

        rst = 1'b1;
        run_sw = 1'b1;
        step_btn = 1'b0;
        rate_sel = RATE_100HZ;
        halt_req = 1'b0;
        cnt_clr = 1'b0;
        repeat (3) tick();
        chk("rst_state", 32'(state_o), 32'(HALT));
        chk("rst_ce", 32'(cpu_ce), 32'd0);
        chk("rst_cnt", cycle_count, 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);

        // Run switch qualifies D+3 edges after reset release.
        rst = 1'b0;
        repeat (6) tick();
        chk("pre_run", 32'(state_o), 32'(HALT));
        chk("pre_run_cnt", cycle_count, 32'd0);
        tick();
        chk("run_entry", 32'(state_o), 32'(RUN));
        chk("run_halted", 32'(halted), 32'd0);

        // P=100 for 1000 cycles.
        n = 0;
        last = -1;
        for (int i = 0; i < 1000; i++) begin
            if (cpu_ce) begin
                if (last < 0) chk("first_ce", 32'(i), 32'd99);
                else chk("ce_spacing", 32'(i - last), 32'd100);
                last = i;
                n++;
            end
            tick();
        end
        chk("ce_1000", 32'(n), 32'd10);
        chk("cnt_10", cycle_count, 32'd10);

        // Switch to every-cycle rate.
        rate_sel = RATE_FULL;
        chk("rate_sw_ce0", 32'(cpu_ce), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_rate_ce", 32'(cpu_ce), 32'd1);
        end
        chk("cnt_14", cycle_count, 32'd14);

        run_sw = 1'b0;
        wait_state(HALT, 20, "run_off");
        tick();
        chk("run_off_ce", 32'(cpu_ce), 32'd0);
        chk("cnt_model1", cycle_count, model_cnt);

        // Bouncy step press while halted.
        start = ce_total;
        rise_i = -1;
        ce_i = -1;
        for (int i = 0; i < 30; i++) begin
            step_btn = (i == 0) || (i >= 2 && i < 13);
            if (dut.step_rise) rise_i = i;
            if (cpu_ce) ce_i = i;
            st[i] = state_o;
            tick();
        end
        step_btn = 1'b0;
        chk("step_rise_at", 32'(rise_i), 32'd8);
        chk("step_ce_at", 32'(ce_i), 32'd9);
        chk("step_ce_n", 32'(ce_total - start), 32'd1);
        chk("step_halt", 32'(st[10]), 32'(HALT));
        chk("step_cnt", cycle_count, model_cnt);

        // Break while run switch drops, then operator acknowledge.
        run_sw = 1'b1;
        wait_state(RUN, 20, "run2");
        chk("run2_ce", 32'(cpu_ce), 32'd1);
        run_sw = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("brk_state", 32'(state_o), 32'(BREAK));
        chk("brk_halted", 32'(halted), 32'd1);
        chk("brk_ce", 32'(cpu_ce), 32'd0);
        start = ce_total;
        wait_state(HALT, 20, "brk_ack");
        chk("brk_no_ce", 32'(ce_total - start), 32'd0);

        // Break, no auto-resume, step past it.
        run_sw = 1'b1;
        wait_state(RUN, 20, "run3");
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("brk2_state", 32'(state_o), 32'(BREAK));
        start = ce_total;
        repeat (10) tick();
        chk("no_resume", 32'(state_o), 32'(BREAK));
        step_btn = 1'b1;
        wait_state(STEP, 20, "brk_step");
        chk("brk_step_ce", 32'(cpu_ce), 32'd1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        step_btn = 1'b0;
        chk("brk_step_back", 32'(state_o), 32'(BREAK));
        chk("brk_step_n", 32'(ce_total - start), 32'd1);
        run_sw = 1'b0;
        wait_state(HALT, 20, "brk_ack2");
        repeat (10) tick();
        chk("cnt_model2", cycle_count, model_cnt);

        // Counter wrap and clear priority at P=1.
        run_sw = 1'b1;
        wait_state(RUN, 20, "run4");
        chk("run4_ce", 32'(cpu_ce), 32'd1);
        force dut.cycle_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_count_q;
        preload = 1'b1;
        tick();
        preload = 1'b0;
        chk("cnt_wrap", cycle_count, 32'd0);
        tick();
        chk("cnt_after_wrap", cycle_count, 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_with_ce", cycle_count, 32'd0);
        chk("cnt_model3", cycle_count, model_cnt);

        // Reset mid-RUN at tick 57 of P=100.
        rate_sel = RATE_100HZ;
        tick();
        repeat (57) tick();
        chk("tick_57", dut.tick_q, 32'd57);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", 32'(state_o), 32'(HALT));
        chk("mid_rst_tick", dut.tick_q, 32'd0);
        chk("mid_rst_cnt", cycle_count, 32'd0);
        repeat (6) tick();
        chk("re_pre_run", 32'(state_o), 32'(HALT));
        tick();
        chk("re_run", 32'(state_o), 32'(RUN));
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            if (cpu_ce) bad++;
            tick();
        end
        chk("re_run_quiet", 32'(bad), 32'd0);
        chk("re_run_ce100", 32'(cpu_ce), 32'd1);

        run_sw = 1'b0;
        repeat (10) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Run/step/halt controller for the single-cycle RV32I core on the 50 MHz board clock.
- Produces a one-cycle clock-enable pulse, cpu_ce, at a switch-selected rate. The core advances only on cpu_ce, so the design has no derived clocks.
- Supports free run, debounced single-step from a push button, and a break state entered on a core halt request (ebreak).
- Keeps a 32-bit count of executed instructions for display.

Parameters:
- CLK_HZ, 50_000_000, board clock frequency; sets the tick periods.
- DEBOUNCE_CYCLES, 1_000_000, cycles an input must be stable before it is accepted (20 ms at 50 MHz).

Ports:
- clk  in  1  board clock.
- rst  in  1  synchronous, active-high reset.
- run_sw  in  1  raw run switch, asynchronous.
- step_btn  in  1  raw step push button, asynchronous.
- rate_sel  in  2  tick rate: 00 = 1 Hz, 01 = 100 Hz, 10 = 10 kHz, 11 = every cycle.
- halt_req  in  1  core requests break; valid only in a cycle where cpu_ce=1.
- cnt_clr  in  1  synchronous clear of cycle_count.
- cpu_ce  out  1  one-cycle clock enable to the core.
- state_o  out  2  current state: 0 = HALT, 1 = RUN, 2 = STEP, 3 = BREAK.
- halted  out  1  high when state is HALT or BREAK.
- cycle_count  out  32  number of cpu_ce pulses since reset or clear.

Behaviour:
- Reset (synchronous, active-high):
  - state HALT, cpu_ce 0, cycle_count 0.
  - Tick counter, synchronizers and debounce counters all 0.
- Input conditioning:
  - run_sw and step_btn each pass through a 2-FF synchronizer, then a debounce filter.
  - The filtered level changes only after the synchronized input has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - A one-cycle rise pulse accompanies each filtered 0->1 transition.
  - Names: run_lvl is the filtered run switch level; step_rise is the step button rise pulse.
- Tick period P by rate_sel:
  - 00: CLK_HZ
  - 01: CLK_HZ/100
  - 10: CLK_HZ/10000
  - 11: 1
  - Any computed P below 1 is clamped to 1.
- Tick counter:
  - Active only in RUN; counts 0..P-1.
  - cpu_ce=1 in the cycle the counter equals P-1, then the counter wraps to 0.
  - Cleared to 0 on entry to RUN and whenever rate_sel differs from its previous-cycle value.
  - Consequence: the first cpu_ce after RUN entry or a rate change comes exactly P cycles later. With P=1, cpu_ce is high every RUN cycle.
- State transitions (evaluated every cycle, priority in listed order):
  - HALT:
    - run_lvl=1 -> RUN.
    - step_rise -> STEP.
    - halt_req is ignored.
  - RUN:
    - halt_req and cpu_ce both high -> BREAK.
    - run_lvl=0 -> HALT; no further cpu_ce is issued in that cycle or later.
    - Otherwise stay in RUN.
  - STEP:
    - cpu_ce=1 for exactly this one cycle.
    - halt_req high -> BREAK; otherwise -> HALT.
    - Step latency: step_rise in cycle n gives cpu_ce in cycle n+1 and HALT in cycle n+2.
  - BREAK:
    - No cpu_ce.
    - step_rise -> STEP, which lets the user step past the break.
    - run_lvl=0 -> HALT (operator acknowledge).
    - run_lvl=1 with no step -> stay in BREAK; free run does not auto-resume.
- Simultaneous events:
  - In RUN, halt_req with cpu_ce beats run_lvl falling.
  - step_rise while in RUN is ignored.
- cycle_count:
  - Increments on every cpu_ce and wraps from 0xFFFF_FFFF to 0.
  - cnt_clr has priority: clear together with cpu_ce yields 0.
- Outputs are registered. cpu_ce is combinational from the state and tick counter registers only; there is no input-to-output combinational path.
- Reset in mid-RUN: HALT the next cycle. If run_sw stays high, the block re-enters RUN once the filter re-qualifies, DEBOUNCE_CYCLES+3 cycles after rst deasserts.

Decomposition:
- Package clk_ctrl_pkg:
  - Enum ctrl_state_t {HALT, RUN, STEP, BREAK}.
  - rate_sel encodings.
  - Function tick_period(rate_sel, CLK_HZ) with clamping to 1.
- Sub-module input_debounce, parameter DEBOUNCE_CYCLES: ports clk, rst, raw_in, level_out, rise_out. Instantiated twice, once for run_sw and once for step_btn.

Test Plan:
Bench configuration for all scenarios: CLK_HZ=10_000, DEBOUNCE_CYCLES=4.
- Reset with run_sw=1 -> state HALT, cpu_ce 0, cycle_count 0 until filter qualifies; then RUN exactly DEBOUNCE_CYCLES+3 cycles after rst falls.
- RUN with rate_sel=01 (P=100) for 1000 cycles -> exactly 10 cpu_ce pulses, spaced 100 cycles apart; cycle_count=10. Switch to rate_sel=11 -> cpu_ce every cycle starting the next cycle.
- Step button bouncing 0/1 for 3 cycles, then held high 10 cycles, while in HALT -> exactly one cpu_ce, one cycle after step_rise; cycle_count +1; back in HALT.
- RUN at P=1, halt_req asserted together with cpu_ce while run_sw is dropping -> BREAK, halted=1, no further cpu_ce. step_rise -> one cpu_ce. run_sw=0 -> HALT.
- cycle_count preloaded via 0xFFFF_FFFF pulses (force) plus one cpu_ce -> 0. cnt_clr together with cpu_ce -> 0.
- Assert rst mid-RUN at count=57 of P=100 -> next cycle HALT, tick counter 0; first cpu_ce after re-entering RUN occurs 100 cycles later.
